// File: rtl/pc_predictor.sv
// Fetch PC register with next-PC select (reset > redirect > advance) and a direct-mapped BTB.
// Latency: PC updates one cycle after the sampling edge; npc and BTB lookup are combinational on PC.
// Backpressure: pcEN low holds PC; redirect and BTB training proceed regardless of pcEN.
module pc_predictor #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               INC         = 4,
    parameter int               BTB_ENTRIES = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             pcEN,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             update_en,
    input  logic [WIDTH-1:0] update_pc,
    input  logic [WIDTH-1:0] update_target,
    input  logic             update_taken,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] npc,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target
);

    localparam int               IDX_W = $clog2(BTB_ENTRIES);
    localparam int               TAG_W = WIDTH - IDX_W - 2;
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] target;
        logic [1:0]       ctr;
    } btb_entry_t;

    btb_entry_t btb [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    btb_entry_t       lk_ent;
    logic             lk_hit;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    btb_entry_t       up_ent;
    logic             up_hit;

    // Byte offset bits do not take part in indexing or tagging.
    logic unused_up_lsb;
    assign unused_up_lsb = ^update_pc[1:0];

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'd3) ? 2'd3 : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    assign npc = PC + INC_W;

    always_comb begin
        lk_idx      = PC[IDX_W+1:2];
        lk_tag      = PC[WIDTH-1:IDX_W+2];
        lk_ent      = btb[lk_idx];
        lk_hit      = lk_ent.valid && (lk_ent.tag == lk_tag);
        pred_taken  = lk_hit && lk_ent.ctr[1];
        pred_target = lk_ent.target;
    end

    always_comb begin
        up_idx = update_pc[IDX_W+1:2];
        up_tag = update_pc[WIDTH-1:IDX_W+2];
        up_ent = btb[up_idx];
        up_hit = up_ent.valid && (up_ent.tag == up_tag);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            PC <= RESET_PC;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb[i].valid <= 1'b0;
                btb[i].ctr   <= 2'd0;
            end
        end else begin
            if (redirect) begin
                PC <= redirect_pc;
            end else if (pcEN) begin
                PC <= pred_taken ? pred_target : npc;
            end

            if (update_en) begin
                if (up_hit) begin
                    if (update_taken) begin
                        btb[up_idx].ctr    <= ctr_inc(up_ent.ctr);
                        btb[up_idx].target <= update_target;
                    end else begin
                        btb[up_idx].ctr <= ctr_dec(up_ent.ctr);
                    end
                end else if (update_taken) begin
                    // Miss on a taken branch: allocate, evicting any aliasing entry.
                    btb[up_idx].valid  <= 1'b1;
                    btb[up_idx].tag    <= up_tag;
                    btb[up_idx].target <= update_target;
                    btb[up_idx].ctr    <= 2'd2;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_predictor.sv
// Bench for pc_predictor: directed scenarios plus random traffic against a behavioural model.
module tb_pc_predictor;

    localparam int          W   = 32;
    localparam logic [31:0] RPC = 32'h100;
    localparam int          N   = 16;

    logic        CLK = 1'b0;
    logic        RST, pcEN, redirect, update_en, update_taken;
    logic [31:0] redirect_pc, update_pc, update_target;
    logic [31:0] PC, npc, pred_target;
    logic        pred_taken;

    int passed = 0;
    int total  = 0;

    // Behavioural model: one record per BTB slot, plus the program counter.
    bit          mv   [N];
    logic [31:0] mtag [N];
    logic [31:0] mtgt [N];
    int          mctr [N];
    logic [31:0] m_pc;

    pc_predictor #(.WIDTH(W), .RESET_PC(RPC), .INC(4), .BTB_ENTRIES(N)) dut (
        .CLK(CLK), .RST(RST), .pcEN(pcEN), .redirect(redirect), .redirect_pc(redirect_pc),
        .update_en(update_en), .update_pc(update_pc), .update_target(update_target),
        .update_taken(update_taken), .PC(PC), .npc(npc), .pred_taken(pred_taken),
        .pred_target(pred_target)
    );

    always #5 CLK = ~CLK;

    function automatic int slot(input logic [31:0] a);
        return int'((a / 4) % N);
    endfunction

    function automatic logic [31:0] tagof(input logic [31:0] a);
        return a / (4 * N);
    endfunction

    function automatic bit m_taken(input logic [31:0] a);
        int s = slot(a);
        return mv[s] && (mtag[s] == tagof(a)) && (mctr[s] >= 2);
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] a);
        return mtgt[slot(a)];
    endfunction

    task automatic idle();
        RST = 0; pcEN = 0; redirect = 0; update_en = 0; update_taken = 0;
        redirect_pc = 0; update_pc = 0; update_target = 0;
    endtask

    // Advance the model by the current inputs, then clock the DUT and settle.
    task automatic step();
        logic [31:0] nxt;
        int s;
        if (RST) begin
            m_pc = RPC;
            for (int i = 0; i < N; i++) begin mv[i] = 0; mctr[i] = 0; end
        end else begin
            if (redirect)  nxt = redirect_pc;
            else if (pcEN) nxt = m_taken(m_pc) ? m_target(m_pc) : m_pc + 32'd4;
            else           nxt = m_pc;
            if (update_en) begin
                s = slot(update_pc);
                if (mv[s] && mtag[s] == tagof(update_pc)) begin
                    if (update_taken) begin
                        mctr[s] = (mctr[s] < 3) ? mctr[s] + 1 : 3;
                        mtgt[s] = update_target;
                    end else begin
                        mctr[s] = (mctr[s] > 0) ? mctr[s] - 1 : 0;
                    end
                end else if (update_taken) begin
                    mv[s] = 1; mtag[s] = tagof(update_pc); mtgt[s] = update_target; mctr[s] = 2;
                end
            end
            m_pc = nxt;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic go_to(input logic [31:0] a);
        idle(); redirect = 1; redirect_pc = a; step(); idle();
    endtask

    task automatic train(input logic [31:0] a, input logic [31:0] t, input bit tk);
        idle(); update_en = 1; update_pc = a; update_target = t; update_taken = tk; step(); idle();
    endtask

    task automatic test_reset();
        idle(); RST = 1; step(); step(); idle();
        total++; if (PC !== 32'h100) begin $display("FAIL reset_pc got=%h want=%h", PC, 32'h100); end else passed++;
        total++; if (npc !== 32'h104) begin $display("FAIL reset_npc got=%h want=%h", npc, 32'h104); end else passed++;
        total++; if (pred_taken !== 1'b0) begin $display("FAIL reset_pred got=%b want=0", pred_taken); end else passed++;
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        exp = 32'h100;
        for (int i = 0; i < 4; i++) begin
            total++; if (PC !== exp) begin $display("FAIL seq_pc[%0d] got=%h want=%h", i, PC, exp); end else passed++;
            total++; if (pred_taken !== 1'b0) begin $display("FAIL seq_pred[%0d] got=%b want=0", i, pred_taken); end else passed++;
            idle(); pcEN = 1; step();
            exp = exp + 32'd4;
        end
    endtask

    task automatic test_stall_redirect();
        go_to(32'h108);
        for (int i = 0; i < 3; i++) step();
        total++; if (PC !== 32'h108) begin $display("FAIL stall_hold got=%h want=%h", PC, 32'h108); end else passed++;
        redirect = 1; redirect_pc = 32'h400; pcEN = 0; step(); idle();
        total++; if (PC !== 32'h400) begin $display("FAIL redirect_nopcen got=%h want=%h", PC, 32'h400); end else passed++;
        redirect = 1; redirect_pc = 32'h500; pcEN = 1; step(); idle();
        total++; if (PC !== 32'h500) begin $display("FAIL redirect_over_pcen got=%h want=%h", PC, 32'h500); end else passed++;
    endtask

    task automatic test_training();
        train(32'h200, 32'h300, 1);
        go_to(32'h1F8);
        pcEN = 1; step();
        total++; if (pred_taken !== 1'b0) begin $display("FAIL train_pre got=%b want=0 pc=%h", pred_taken, PC); end else passed++;
        step();
        total++; if (PC !== 32'h200) begin $display("FAIL train_reach got=%h want=%h", PC, 32'h200); end else passed++;
        total++; if (pred_taken !== 1'b1) begin $display("FAIL train_pred got=%b want=1", pred_taken); end else passed++;
        total++; if (pred_target !== 32'h300) begin $display("FAIL train_tgt got=%h want=%h", pred_target, 32'h300); end else passed++;
        step(); idle();
        total++; if (PC !== 32'h300) begin $display("FAIL train_jump got=%h want=%h", PC, 32'h300); end else passed++;
    endtask

    task automatic test_saturation();
        // Counter starts at 2; expected pred_taken after each update in the sequence.
        bit tk  [10] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
        bit exp [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
        go_to(32'h200);
        for (int i = 0; i < 10; i++) begin
            update_en = 1; update_pc = 32'h200; update_target = 32'h300; update_taken = tk[i];
            total++; if (pred_taken !== m_taken(PC)) begin $display("FAIL sat_same_cycle[%0d] got=%b want=%b", i, pred_taken, m_taken(PC)); end else passed++;
            step(); idle();
            total++; if (pred_taken !== exp[i]) begin $display("FAIL sat_pred[%0d] got=%b want=%b", i, pred_taken, exp[i]); end else passed++;
        end
    endtask

    task automatic test_alias();
        go_to(32'h200);
        train(32'h200 + 32'(4 * N), 32'h600, 1);
        total++; if (pred_taken !== 1'b0) begin $display("FAIL alias_miss got=%b want=0", pred_taken); end else passed++;
        go_to(32'h200 + 32'(4 * N));
        total++; if (pred_taken !== 1'b1) begin $display("FAIL alias_hit got=%b want=1", pred_taken); end else passed++;
        total++; if (pred_target !== 32'h600) begin $display("FAIL alias_tgt got=%h want=%h", pred_target, 32'h600); end else passed++;
    endtask

    task automatic test_wrap();
        go_to(32'hFFFF_FFFC);
        total++; if (npc !== 32'h0) begin $display("FAIL wrap_npc got=%h want=0", npc); end else passed++;
        pcEN = 1; step(); idle();
        total++; if (PC !== 32'h0) begin $display("FAIL wrap_pc got=%h want=0", PC); end else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] probe [3] = '{32'h200, 32'h240, 32'h120};
        train(32'h120, 32'h700, 1);
        idle(); RST = 1; redirect = 1; redirect_pc = 32'h800; pcEN = 1;
        update_en = 1; update_pc = 32'h120; update_target = 32'h900; update_taken = 1;
        step(); idle();
        total++; if (PC !== RPC) begin $display("FAIL rstmid_pc got=%h want=%h", PC, RPC); end else passed++;
        for (int i = 0; i < 3; i++) begin
            go_to(probe[i]);
            total++; if (pred_taken !== 1'b0) begin $display("FAIL rstmid_miss[%0d] got=%b want=0", i, pred_taken); end else passed++;
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [6] = '{32'h200, 32'h240, 32'h204, 32'h280, 32'h1FC, 32'h3C0};
        for (int c = 0; c < 400; c++) begin
            idle();
            RST          = ($urandom_range(0, 99) == 0);
            pcEN         = ($urandom_range(0, 3) != 0);
            redirect     = ($urandom_range(0, 5) == 0);
            redirect_pc  = pool[$urandom_range(0, 5)];
            update_en    = ($urandom_range(0, 1) == 1);
            update_pc    = pool[$urandom_range(0, 5)];
            update_target = pool[$urandom_range(0, 5)] ^ 32'h1000;
            update_taken = ($urandom_range(0, 2) != 0);
            step();
            total++; if (PC !== m_pc) begin $display("FAIL rand_pc[%0d] got=%h want=%h", c, PC, m_pc); end else passed++;
            total++; if (npc !== m_pc + 32'd4) begin $display("FAIL rand_npc[%0d] got=%h want=%h", c, npc, m_pc + 32'd4); end else passed++;
            total++; if (pred_taken !== m_taken(m_pc)) begin $display("FAIL rand_pred[%0d] got=%b want=%b", c, pred_taken, m_taken(m_pc)); end else passed++;
            if (m_taken(m_pc)) begin
                total++; if (pred_target !== m_target(m_pc)) begin $display("FAIL rand_tgt[%0d] got=%h want=%h", c, pred_target, m_target(m_pc)); end else passed++;
            end
        end
        idle();
    endtask

    initial begin
        idle();
        m_pc = RPC;
        test_reset();
        test_sequential();
        test_stall_redirect();
        test_training();
        test_saturation();
        test_alias();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
